memory_stage: RTL and testbench

Pipeline M stage, directly downstream of the execute stage. Consumes the execute stage's registered outputs (ALU result, store data, destination register, control bits) and performs loads and stores over a ready/valid data-memory port. Handles byte/halfword lane alignment and load sign/zero extension, and stalls the pipeline while the memory is not ready. Registers the final write-back value into the M/W pipeline register; `resultW` also serves as the forwarding source back into execute.

---
 rtl/mem_pkg.sv | 15 +
 rtl/load_store_align.sv | 71 +++++++
 rtl/memory_stage.sv | 132 +++++++++++++
 tb/tb_memory_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the memory stage: access size codes and FSM states.
package mem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic {
        MS_IDLE = 1'b0,
        MS_WAIT = 1'b1
    } ms_state_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering: store byte enables and replication, load lane
// extraction with sign/zero extension, and misalignment/illegal-size detection.
module load_store_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  str_ctrl,
    input  logic [31:0] store_data,
    input  logic [31:0] read_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        bad_access
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = 8'h00;
        case (addr_lo)
            2'd0: byte_lane = read_word[7:0];
            2'd1: byte_lane = read_word[15:8];
            2'd2: byte_lane = read_word[23:16];
            2'd3: byte_lane = read_word[31:24];
            default: byte_lane = 8'h00;
        endcase
        half_lane = addr_lo[1] ? read_word[31:16] : read_word[15:0];
    end

    always_comb begin
        be         = 4'b0000;
        wdata      = store_data;
        load_data  = read_word;
        bad_access = 1'b0;
        case (str_ctrl)
            SZ_B: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{byte_lane[7]}}, byte_lane};
            end
            SZ_BU: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = {24'h000000, byte_lane};
            end
            SZ_H: begin
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                wdata      = {2{store_data[15:0]}};
                load_data  = {{16{half_lane[15]}}, half_lane};
                bad_access = addr_lo[0];
            end
            SZ_HU: begin
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                wdata      = {2{store_data[15:0]}};
                load_data  = {16'h0000, half_lane};
                bad_access = addr_lo[0];
            end
            SZ_W: begin
                be         = 4'b1111;
                wdata      = store_data;
                load_data  = read_word;
                bad_access = (addr_lo != 2'b00);
            end
            default: begin
                bad_access = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Pipeline M stage: issues loads/stores on a ready/valid data port, stalls
// while the memory is busy, and registers the write-back value into M/W.
module memory_stage
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  strCtrlM,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        MemtoRegM,
    input  logic [31:0] ALUoutM,
    input  logic [31:0] r2M,
    input  logic [4:0]  rdM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stallM,
    output logic        mem_err,
    output logic        RegWriteW,
    output logic [4:0]  rdW,
    output logic [31:0] resultW
);

    ms_state_t   state_reg;
    logic [31:0] addr_reg;
    logic        we_reg;
    logic [3:0]  be_reg;
    logic [31:0] wdata_reg;
    logic [2:0]  str_ctrl_reg;
    logic        mem_to_reg_reg;
    logic        reg_write_reg;
    logic [4:0]  rd_reg;

    logic        in_wait;
    logic        mem_op;
    logic        legal_op;
    logic [1:0]  align_addr_lo;
    logic [2:0]  align_str_ctrl;
    logic [3:0]  align_be;
    logic [31:0] align_wdata;
    logic [31:0] load_data;
    logic        bad_access;

    assign in_wait = (state_reg == MS_WAIT);
    assign mem_op  = MemWriteM | MemtoRegM;

    // In WAIT the aligner sees the latched access so load extraction uses the
    // original address/size even if upstream changes the live inputs.
    assign align_addr_lo  = in_wait ? addr_reg[1:0] : ALUoutM[1:0];
    assign align_str_ctrl = in_wait ? str_ctrl_reg  : strCtrlM;

    load_store_align u_align (
        .addr_lo    (align_addr_lo),
        .str_ctrl   (align_str_ctrl),
        .store_data (r2M),
        .read_word  (dmem_rdata),
        .be         (align_be),
        .wdata      (align_wdata),
        .load_data  (load_data),
        .bad_access (bad_access)
    );

    assign legal_op = !in_wait && mem_op && !bad_access;

    assign dmem_req   = !rst && (legal_op || in_wait);
    assign dmem_we    = in_wait ? we_reg : MemWriteM;
    assign dmem_addr  = in_wait ? {addr_reg[31:2], 2'b00} : {ALUoutM[31:2], 2'b00};
    assign dmem_be    = in_wait ? be_reg : (MemWriteM ? align_be : 4'b0000);
    assign dmem_wdata = in_wait ? wdata_reg : align_wdata;
    assign stallM     = dmem_req && !dmem_ready;
    assign mem_err    = !rst && !in_wait && mem_op && bad_access;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= MS_IDLE;
            RegWriteW      <= 1'b0;
            rdW            <= 5'd0;
            resultW        <= 32'd0;
            addr_reg       <= 32'd0;
            we_reg         <= 1'b0;
            be_reg         <= 4'b0000;
            wdata_reg      <= 32'd0;
            str_ctrl_reg   <= SZ_W;
            mem_to_reg_reg <= 1'b0;
            reg_write_reg  <= 1'b0;
            rd_reg         <= 5'd0;
        end else begin
            case (state_reg)
                MS_IDLE: begin
                    if (!mem_op) begin
                        RegWriteW <= RegWriteM;
                        rdW       <= rdM;
                        resultW   <= ALUoutM;
                    end else if (bad_access) begin
                        RegWriteW <= 1'b0;
                        rdW       <= 5'd0;
                        resultW   <= 32'd0;
                    end else if (dmem_ready) begin
                        RegWriteW <= RegWriteM;
                        rdW       <= rdM;
                        resultW   <= MemtoRegM ? load_data : ALUoutM;
                    end else begin
                        addr_reg       <= ALUoutM;
                        we_reg         <= MemWriteM;
                        be_reg         <= MemWriteM ? align_be : 4'b0000;
                        wdata_reg      <= align_wdata;
                        str_ctrl_reg   <= strCtrlM;
                        mem_to_reg_reg <= MemtoRegM;
                        reg_write_reg  <= RegWriteM;
                        rd_reg         <= rdM;
                        state_reg      <= MS_WAIT;
                    end
                end
                MS_WAIT: begin
                    if (dmem_ready) begin
                        RegWriteW <= reg_write_reg;
                        rdW       <= rd_reg;
                        resultW   <= mem_to_reg_reg ? load_data : addr_reg;
                        state_reg <= MS_IDLE;
                    end
                end
                default: state_reg <= MS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: ALU pass-through, loads/stores with and
// without wait states, error bubbles and reset during an outstanding access.
module tb_memory_stage;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  strCtrlM;
    logic        RegWriteM, MemWriteM, MemtoRegM;
    logic [31:0] ALUoutM, r2M;
    logic [4:0]  rdM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        stallM, mem_err;
    logic        RegWriteW;
    logic [4:0]  rdW;
    logic [31:0] resultW;

    int check_count = 0;
    int error_count = 0;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk        (clk),
        .rst        (rst),
        .strCtrlM   (strCtrlM),
        .RegWriteM  (RegWriteM),
        .MemWriteM  (MemWriteM),
        .MemtoRegM  (MemtoRegM),
        .ALUoutM    (ALUoutM),
        .r2M        (r2M),
        .rdM        (rdM),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .stallM     (stallM),
        .mem_err    (mem_err),
        .RegWriteW  (RegWriteW),
        .rdW        (rdW),
        .resultW    (resultW)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        if (obs !== exp) begin
            error_count++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    // Apply one M-stage op just after a rising edge.
    task automatic drive(input logic [2:0] sz, input logic rw, input logic mw, input logic m2r,
                         input logic [31:0] alu, input logic [31:0] r2, input logic [4:0] rd,
                         input logic rdy, input logic [31:0] rdata);
        strCtrlM   = sz;
        RegWriteM  = rw;
        MemWriteM  = mw;
        MemtoRegM  = m2r;
        ALUoutM    = alu;
        r2M        = r2;
        rdM        = rd;
        dmem_ready = rdy;
        dmem_rdata = rdata;
    endtask

    task automatic to_mid;  @(negedge clk); endtask
    task automatic to_post; @(posedge clk); #1; endtask

    initial begin
        rst = 1'b1;
        drive(SZ_W, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 5'd4, 1'b1, 32'h0);
        to_mid;
        check("rst_req", {31'd0, dmem_req}, 32'd0);
        check("rst_err", {31'd0, mem_err}, 32'd0);
        to_post;
        check("rst_resultW", resultW, 32'd0);
        check("rst_rdW", {27'd0, rdW}, 32'd0);
        check("rst_RegWriteW", {31'd0, RegWriteW}, 32'd0);

        // ALU pass-through
        rst = 1'b0;
        drive(SZ_W, 1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd5, 1'b0, 32'h0);
        to_mid;
        check("alu_req", {31'd0, dmem_req}, 32'd0);
        check("alu_stall", {31'd0, stallM}, 32'd0);
        to_post;
        check("alu_resultW", resultW, 32'h0000_1234);
        check("alu_rdW", {27'd0, rdW}, 32'd5);
        check("alu_RegWriteW", {31'd0, RegWriteW}, 32'd1);

        // LB 0x103, zero wait
        drive(SZ_B, 1'b1, 1'b0, 1'b1, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 32'h80FF_0000);
        to_mid;
        check("lb_req", {31'd0, dmem_req}, 32'd1);
        check("lb_we", {31'd0, dmem_we}, 32'd0);
        check("lb_be", {28'd0, dmem_be}, 32'd0);
        check("lb_addr", dmem_addr, 32'h0000_0100);
        check("lb_stall", {31'd0, stallM}, 32'd0);
        to_post;
        check("lb_resultW", resultW, 32'hFFFF_FF80);
        check("lb_rdW", {27'd0, rdW}, 32'd7);

        // SH 0x102 with 3 wait cycles; live inputs scrambled while waiting
        drive(SZ_H, 1'b0, 1'b1, 1'b0, 32'h0000_0102, 32'h0000_ABCD, 5'd0, 1'b0, 32'h0);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) dmem_ready = 1'b1;
            to_mid;
            check($sformatf("sh_req_c%0d", c), {31'd0, dmem_req}, 32'd1);
            check($sformatf("sh_we_c%0d", c), {31'd0, dmem_we}, 32'd1);
            check($sformatf("sh_be_c%0d", c), {28'd0, dmem_be}, 32'h0000_000C);
            check($sformatf("sh_wdata_c%0d", c), dmem_wdata, 32'hABCD_ABCD);
            check($sformatf("sh_addr_c%0d", c), dmem_addr, 32'h0000_0100);
            check($sformatf("sh_stall_c%0d", c), {31'd0, stallM}, (c < 3) ? 32'd1 : 32'd0);
            to_post;
            if (c < 3) begin
                check($sformatf("sh_hold_resultW_c%0d", c), resultW, 32'hFFFF_FF80);
                check($sformatf("sh_hold_rdW_c%0d", c), {27'd0, rdW}, 32'd7);
                drive(SZ_B, 1'b1, 1'b0, 1'b1, 32'h0000_0555, 32'h1111_1111, 5'd30, 1'b0, 32'h0);
            end
        end
        check("sh_RegWriteW", {31'd0, RegWriteW}, 32'd0);
        check("sh_resultW", resultW, 32'h0000_0102);

        // SB 0x101: lane replication
        drive(SZ_B, 1'b0, 1'b1, 1'b0, 32'h0000_0101, 32'h0000_005A, 5'd0, 1'b1, 32'h0);
        to_mid;
        check("sb_be", {28'd0, dmem_be}, 32'h0000_0002);
        check("sb_wdata", dmem_wdata, 32'h5A5A_5A5A);
        to_post;

        // Misaligned LW -> bubble
        drive(SZ_W, 1'b1, 1'b0, 1'b1, 32'h0000_0102, 32'h0, 5'd9, 1'b1, 32'hDEAD_BEEF);
        to_mid;
        check("lw_mis_err", {31'd0, mem_err}, 32'd1);
        check("lw_mis_req", {31'd0, dmem_req}, 32'd0);
        check("lw_mis_stall", {31'd0, stallM}, 32'd0);
        to_post;
        check("lw_mis_RegWriteW", {31'd0, RegWriteW}, 32'd0);
        check("lw_mis_rdW", {27'd0, rdW}, 32'd0);
        check("lw_mis_resultW", resultW, 32'd0);

        // Legal LW afterwards
        drive(SZ_W, 1'b1, 1'b0, 1'b1, 32'h0000_0104, 32'h0, 5'd9, 1'b1, 32'hDEAD_BEEF);
        to_mid;
        check("lw_err", {31'd0, mem_err}, 32'd0);
        check("lw_req", {31'd0, dmem_req}, 32'd1);
        to_post;
        check("lw_resultW", resultW, 32'hDEAD_BEEF);
        check("lw_rdW", {27'd0, rdW}, 32'd9);

        // Illegal size code on a load
        drive(3'b011, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 5'd2, 1'b1, 32'h0);
        to_mid;
        check("ill_err", {31'd0, mem_err}, 32'd1);
        check("ill_req", {31'd0, dmem_req}, 32'd0);
        to_post;
        check("ill_RegWriteW", {31'd0, RegWriteW}, 32'd0);

        // LW that goes to WAIT, then reset while waiting
        drive(SZ_W, 1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'h0, 5'd6, 1'b0, 32'h0);
        to_mid;
        check("rw_stall", {31'd0, stallM}, 32'd1);
        to_post;
        rst = 1'b1;
        drive(SZ_W, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0, 5'd0, 1'b0, 32'h0);
        to_mid;
        check("rw_rst_req", {31'd0, dmem_req}, 32'd0);
        to_post;
        rst = 1'b0;
        to_mid;
        check("rw_after_req", {31'd0, dmem_req}, 32'd0);
        check("rw_after_stall", {31'd0, stallM}, 32'd0);
        check("rw_after_RegWriteW", {31'd0, RegWriteW}, 32'd0);
        to_post;

        // Back-to-back LHU 0x200 / SW 0x204, zero wait
        drive(SZ_HU, 1'b1, 1'b0, 1'b1, 32'h0000_0200, 32'h0, 5'd3, 1'b1, 32'h0000_F00D);
        to_mid;
        check("lhu_req", {31'd0, dmem_req}, 32'd1);
        check("lhu_addr", dmem_addr, 32'h0000_0200);
        check("lhu_stall", {31'd0, stallM}, 32'd0);
        to_post;
        check("lhu_resultW", resultW, 32'h0000_F00D);
        check("lhu_rdW", {27'd0, rdW}, 32'd3);
        drive(SZ_W, 1'b0, 1'b1, 1'b0, 32'h0000_0204, 32'h1122_3344, 5'd0, 1'b1, 32'h0);
        to_mid;
        check("sw_req", {31'd0, dmem_req}, 32'd1);
        check("sw_we", {31'd0, dmem_we}, 32'd1);
        check("sw_be", {28'd0, dmem_be}, 32'h0000_000F);
        check("sw_wdata", dmem_wdata, 32'h1122_3344);
        check("sw_stall", {31'd0, stallM}, 32'd0);
        to_post;
        check("sw_RegWriteW", {31'd0, RegWriteW}, 32'd0);

        // LH sign extension from upper half
        drive(SZ_H, 1'b1, 1'b0, 1'b1, 32'h0000_0302, 32'h0, 5'd11, 1'b1, 32'h8001_1234);
        to_post;
        check("lh_resultW", resultW, 32'hFFFF_8001);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
